lab2_serial_adder: RTL

Bit-serial ripple-carry adder: the addition counterpart of the lab's 4-bit ripple-borrow subtractor, built as a multi-cycle datapath. On a start handshake it latches two WIDTH-bit operands and a carry-in, computes one sum bit per clock LSB-first through a single full-adder cell and a carry flip-flop, then presents sum and carry-out with a one-cycle done pulse. It is the reference adder against which the lab's subtractor results (X − Y = X + ~Y + 1) are cross-checked in the lab test benches.

---
 rtl/lab2_serial_adder.sv | 109 ++++++++++
 1 files changed

// File: rtl/lab2_serial_adder.sv
// Bit-serial ripple-carry adder: one full-adder cell and a carry FF, LSB first.
// WIDTH+1 cycles per add. A start seen on the edge leaving DONE chains the next operation.
module lab2_serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             s_bit;
  logic             c_next;
  logic             last_bit;

  assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_next   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        // DONE always leaves after one cycle; a start on that edge loads directly
        if (start_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          c_d     = cin_i;
          cnt_d   = '0;
          ps_d    = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = c_next;
        ps_d   = {s_bit, ps_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = {s_bit, ps_q[WIDTH-1:1]};
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == SHIFT);
  assign done_o = (state_q == DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule
